// File: rtl/adc_fifo_reader_if.sv
// Sample-FIFO read port and byte-sink write port of the ADC frame reader.
// The master side is the reader; the slave side is the FIFO/sink environment.
interface adc_fifo_reader_if;
  logic       fifo_empty_i;
  logic [7:0] fifo_data_i;
  logic       fifo_rd_en_o;
  logic       tx_txe_i;
  logic       tx_wr_o;
  logic [7:0] tx_dout_o;

  modport master (
    input  fifo_empty_i, fifo_data_i, tx_txe_i,
    output fifo_rd_en_o, tx_wr_o, tx_dout_o
  );

  modport slave (
    output fifo_empty_i, fifo_data_i, tx_txe_i,
    input  fifo_rd_en_o, tx_wr_o, tx_dout_o
  );
endinterface

// File: rtl/adc_fifo_reader.sv
// Streams one framed ADC readout: header, big-endian sample count, the samples
// pulled from a FIFO one at a time, then an 8-bit additive checksum.
module adc_fifo_reader #(
  parameter logic [7:0] HDR_BYTE = 8'hAC,
  parameter int         CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [CNT_W-1:0]  count_i,
  output logic              busy_o,
  output logic              done_o,
  adc_fifo_reader_if.master bus
);
  localparam int NB    = CNT_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_LEN   = 3'd2;
  localparam logic [2:0] S_FETCH = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_SEND  = 3'd5;
  localparam logic [2:0] S_CSUM  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_count_q;
  logic [CNT_W-1:0] r_remaining;
  logic [7:0]       r_csum;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_hold;

  logic [7:0]       w_len_byte;
  logic             w_len_last;
  logic             w_tx_wr;
  logic [7:0]       w_tx_dout;
  logic             w_rd_en;
  logic             w_xfer;

  // Count byte selected by the LEN index, most significant byte first
  always_comb begin
    w_len_byte = 8'h00;
    for (int b = 0; b < NB; b++) begin
      w_len_byte = (r_idx == IDX_W'(b)) ? r_count_q[(NB-1-b)*8 +: 8] : w_len_byte;
    end
  end

  // Sink write strobe and byte, decoded from the registered state
  always_comb begin
    w_tx_wr   = 1'b0;
    w_tx_dout = 8'h00;
    case (r_state)
      S_HDR: begin
        w_tx_wr   = 1'b1;
        w_tx_dout = HDR_BYTE;
      end
      S_LEN: begin
        w_tx_wr   = 1'b1;
        w_tx_dout = w_len_byte;
      end
      S_SEND: begin
        w_tx_wr   = 1'b1;
        w_tx_dout = r_hold;
      end
      S_CSUM: begin
        w_tx_wr   = 1'b1;
        w_tx_dout = r_csum;
      end
      default: begin
        w_tx_wr   = 1'b0;
        w_tx_dout = 8'h00;
      end
    endcase
  end

  assign w_len_last = (r_idx == IDX_W'(NB - 1));
  assign w_xfer     = w_tx_wr & bus.tx_txe_i;
  // Gating with abort keeps a cancelled frame from consuming a FIFO byte
  assign w_rd_en    = (r_state == S_FETCH) & ~bus.fifo_empty_i & ~abort_i;

  assign bus.fifo_rd_en_o = w_rd_en;
  assign bus.tx_wr_o      = w_tx_wr;
  assign bus.tx_dout_o    = w_tx_dout;
  assign busy_o           = (r_state != S_IDLE);
  assign done_o           = (r_state == S_DONE);

  // Frame sequencer; abort takes priority over every non-idle transition
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_state     <= S_IDLE;
      r_count_q   <= '0;
      r_remaining <= '0;
      r_csum      <= 8'h00;
      r_idx       <= '0;
      r_hold      <= 8'h00;
    end else if ((r_state != S_IDLE) && abort_i) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state     <= S_HDR;
            r_count_q   <= count_i;
            r_remaining <= count_i;
            r_csum      <= 8'h00;
            r_idx       <= '0;
          end
        end
        S_HDR: begin
          if (w_xfer) r_state <= S_LEN;
        end
        S_LEN: begin
          if (w_xfer) begin
            r_idx <= r_idx + IDX_W'(1);
            if (w_len_last) r_state <= (r_remaining != '0) ? S_FETCH : S_CSUM;
          end
        end
        S_FETCH: begin
          if (w_rd_en) r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_hold      <= bus.fifo_data_i;
          r_csum      <= r_csum + bus.fifo_data_i;
          r_remaining <= r_remaining - CNT_W'(1);
          r_state     <= S_SEND;
        end
        S_SEND: begin
          if (w_xfer) r_state <= (r_remaining != '0) ? S_FETCH : S_CSUM;
        end
        S_CSUM: begin
          if (w_xfer) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/adc_fifo_reader.md
ADC_FIFO_READER -- requirements
Module: adc_fifo_reader

Interface
REQ-001 The block SHALL have parameter HDR_BYTE, default 8'hAC, the frame start marker.
REQ-002 The block SHALL have parameter CNT_W, default 32, the width of the sample-count field.
REQ-003 Port clk, input, 1: the single clock for all logic.
REQ-004 Port reset_i, input, 1: reset, asynchronous and active-low.
REQ-005 Port start_i, input, 1: one-cycle pulse that begins a readout frame.
REQ-006 Port abort_i, input, 1: level input that cancels a frame in progress.
REQ-007 Port count_i, input, CNT_W: number of sample bytes to stream; sampled on an accepted start.
REQ-008 Port fifo_empty_i, input, 1: the sample FIFO holds no data.
REQ-009 Port fifo_data_i, input, 8: FIFO read data, valid exactly one cycle after fifo_rd_en_o.
REQ-010 Port fifo_rd_en_o, output, 1: FIFO read strobe, one cycle per byte.
REQ-011 Port tx_txe_i, input, 1: the downstream byte sink accepts a byte this cycle.
REQ-012 Port tx_wr_o, output, 1: tx_dout_o is valid; the transfer occurs when tx_wr_o and tx_txe_i are both 1.
REQ-013 Port tx_dout_o, output, 8: outgoing frame byte.
REQ-014 Port busy_o, output, 1: high in every state except IDLE.
REQ-015 Port done_o, output, 1: one-cycle pulse after the checksum byte is transferred.

Function
REQ-016 Frame order SHALL be: HDR_BYTE; then count, CNT_W/8 bytes, MSB first; then count data bytes; then CSUM.
- CSUM is the 8-bit sum, modulo 256, of all data bytes.
REQ-017 The states SHALL be IDLE, HDR, LEN, FETCH, WAIT, SEND, CSUM and DONE.
REQ-018 IDLE -> HDR on start_i; start_i SHALL be ignored in every other state.
- On this transition: latch count_i into count_q, load remaining = count_i, clear the checksum accumulator, clear the LEN byte index.
REQ-019 HDR: drive HDR_BYTE with tx_wr_o=1 until the transfer occurs, then go to LEN.
REQ-020 LEN: drive byte[index] of count_q, MSB first, and advance the index on each transfer.
- After the last byte: go to FETCH if remaining != 0, otherwise go to CSUM.
REQ-021 FETCH: assert fifo_rd_en_o for exactly one cycle when fifo_empty_i=0, then go to WAIT.
- While the FIFO is empty: stall with no read and no timeout.
REQ-022 WAIT: capture fifo_data_i into the hold register, add it to the checksum, decrement remaining, go to SEND.
REQ-023 SEND: drive the hold register with tx_wr_o=1 until the transfer occurs.
- Then go to FETCH if remaining != 0, otherwise go to CSUM.
REQ-024 CSUM: drive the checksum with tx_wr_o=1 until the transfer occurs, then go to DONE.
REQ-025 DONE: assert done_o for one cycle and go to IDLE.
REQ-026 tx_dout_o SHALL hold stable while tx_wr_o=1 and tx_txe_i=0.
REQ-027 fifo_rd_en_o SHALL never be asserted while fifo_empty_i=1, and never more than count_q times per frame.
REQ-028 abort_i=1 in any non-IDLE state SHALL force IDLE on the next edge.
- No done_o; fifo_rd_en_o and tx_wr_o deassert.
- A byte read into WAIT is discarded.
- abort_i in IDLE has no effect.
REQ-029 count_i=0 SHALL produce the header, all-zero count bytes and CSUM=8'h00, with no FIFO reads.
REQ-030 remaining and checksum SHALL wrap modulo their widths.
- Frame length is count_q + CNT_W/8 + 2 bytes.
- Minimum data-phase cost: 3 cycles per byte.

Reset
REQ-031 While reset_i=0, the block SHALL be in state IDLE with all outputs at these values, independent of clk:
- fifo_rd_en_o=0, tx_wr_o=0, tx_dout_o=8'h00, busy_o=0, done_o=0.
- count_q, remaining, checksum, index and the hold register = 0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; after release the block waits for a new start_i.

Verification
REQ-033 count_i=3, FIFO holds 8'h01, 8'h02, 8'hFF, tx_txe_i=1 -> exactly 3 reads; done_o one cycle after the last transfer. Output bytes:
- AC 00 00 00 03 01 02 FF 02
REQ-034 count_i=0 -> no fifo_rd_en_o. Output bytes:
- AC 00 00 00 00 00
REQ-035 count_i=2, tx_txe_i=0 for 5 cycles during each byte -> tx_dout_o stable while stalled, no duplicate or lost bytes, same checksum as the unstalled run.
REQ-036 count_i=4, FIFO empty for 10 cycles after the 2nd byte -> no reads while empty; the frame completes correctly after data arrives.
REQ-037 abort_i pulsed in WAIT of the 2nd data byte -> busy_o=0 next cycle, no done_o, no further reads; a new start_i with count_i=1 produces a correct 7-byte frame.
REQ-038 start_i pulsed mid-frame, and reset_i=0 pulsed in SEND -> the mid-frame start_i is ignored; the reset pulse immediately gives the IDLE output values; the next frame is correct.
